// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch front end: issues one request at a time to
// instruction memory, buffers returned words, and restarts fetch on redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_addr_o,
  output logic [31:0] instr_data_o,
  input  logic        instr_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        misalign_err_o
);

  localparam int unsigned     PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [2:0]      DEPTH_C  = 3'(BUF_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic          drop_q, drop_d;
  logic [2:0]    count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   head_addr_q, head_addr_d;
  logic [31:0]   head_data_q, head_data_d;
  logic          misalign_q, misalign_d;
  logic          can_issue;
  logic          push, pop;

  logic [31:0] buf_addr_q [BUF_DEPTH];
  logic [31:0] buf_data_q [BUF_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A redirect cancels any buffer traffic happening in the same cycle.
  assign push = (state_q == S_WAIT) && imem_rvalid_i && !drop_q && !redirect_valid_i;
  assign pop  = (count_q != 3'd0) && instr_ready_i && !redirect_valid_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    drop_d       = drop_q;
    count_d      = count_q + {2'b00, push} - {2'b00, pop};
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    head_addr_d  = head_addr_q;
    head_data_d  = head_data_q;
    misalign_d   = 1'b0;
    can_issue    = fetch_en_i && (count_d < DEPTH_C);

    // Head registers follow the FIFO; an incoming word bypasses straight in when empty.
    if ((count_q - {2'b00, pop}) != 3'd0) begin
      head_addr_d = buf_addr_q[rd_ptr_d];
      head_data_d = buf_data_q[rd_ptr_d];
    end else if (push) begin
      head_addr_d = fetch_addr_q;
      head_data_d = imem_rdata_i;
    end

    case (state_q)
      S_IDLE: if (can_issue) state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          fetch_addr_d = pc_q;
          pc_d         = pc_q + 32'd4;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          drop_d  = 1'b0;
          state_d = can_issue ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Drop is only armed while a response is still owed after this cycle.
    if (redirect_valid_i) begin
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      misalign_d = |redirect_pc_i[1:0];
      count_d    = 3'd0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      if (state_q == S_REQ) begin
        state_d = imem_gnt_i ? S_WAIT : S_IDLE;
        drop_d  = imem_gnt_i;
      end else if (state_q == S_WAIT) begin
        state_d = imem_rvalid_i ? S_IDLE : S_WAIT;
        drop_d  = !imem_rvalid_i;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= 32'd0;
      drop_q       <= 1'b0;
      count_q      <= 3'd0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      head_addr_q  <= 32'd0;
      head_data_q  <= 32'd0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      drop_q       <= drop_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      head_addr_q  <= head_addr_d;
      head_data_q  <= head_data_d;
      misalign_q   <= misalign_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= fetch_addr_q;
      buf_data_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  assign imem_req_o     = (state_q == S_REQ);
  assign imem_addr_o    = pc_q;
  assign instr_valid_o  = (count_q != 3'd0);
  assign instr_addr_o   = head_addr_q;
  assign instr_data_o   = head_data_q;
  assign misalign_err_o = misalign_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Holds the architectural PC and fetches instruction words from instruction memory through a request/grant/response handshake. Fetched {address, word} pairs are buffered and presented to decode and the branch/jump units, which use them as iaddr/idata. The same units drive a computed next-PC back as a redirect, which flushes the buffer and restarts fetch at the target. Sits between instruction memory and decode/execute.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
BUF_DEPTH, 2, instruction buffer entries; legal values 1..4.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  permits new fetch requests; in-flight requests still complete
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch word address
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response data valid; at most one response per granted request, in order
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  buffer head valid toward decode
instr_addr  out  32  address of the head instruction (iaddr)
instr_data  out  32  head instruction word (idata)
instr_ready  in  1  decode consumes the head this cycle
redirect_valid  in  1  branch/jump target valid (one-cycle pulse)
redirect_pc  in  32  new PC (iaddr_val from branch/jump units)
misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] was non-zero

Behaviour:
- Reset (async assert, sync deassert handled upstream): pc=RESET_PC, state=IDLE, buffer count=0, drop=0; imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_addr=0, instr_data=0, misalign_err=0.
- At most one outstanding request (granted, response pending).
- FSM states: IDLE, REQ, WAIT.
  - IDLE: go to REQ when fetch_en=1 and (count + outstanding) < BUF_DEPTH.
  - REQ: imem_req=1, imem_addr=pc. imem_req and imem_addr stay stable until imem_gnt. On gnt: pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), go to WAIT.
  - WAIT: on imem_rvalid, push {fetch address, imem_rdata} unless drop=1. If drop=1, discard the word and clear drop. Go to REQ if the IDLE condition holds, else IDLE.
  - imem_rvalid and imem_gnt never coincide for the same request. A response with no outstanding request is ignored.
- Buffer: FIFO of BUF_DEPTH entries.
  - Head is driven registered-out: instr_valid = (count != 0).
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push never overflows: issue is gated by count + outstanding.
  - instr_addr/instr_data hold their last value when empty.
- Redirect (highest priority, acts in the cycle redirect_valid=1):
  - Buffer flushed (count=0). Any same-cycle push or pop is cancelled.
  - pc <= {redirect_pc[31:2], 2'b00}; misalign_err=1 if redirect_pc[1:0] != 0.
  - If a request is outstanding (WAIT), or granted in this same cycle, drop <= 1 so its response is discarded.
  - If in REQ without gnt: the pending request is withdrawn (imem_req low next cycle). Re-issue from the new pc.
  - instr_valid=0 in the next cycle. The first target instruction is visible no earlier than 3 cycles after redirect (with gnt=1 and rvalid one cycle after gnt).
- fetch_en=0: no new requests. An outstanding response is still accepted and buffered.
- Latency: with imem_gnt=1 and imem_rvalid one cycle after gnt, the first instr_valid after reset release and fetch_en=1 comes 3 cycles later.
- Steady-state throughput: one instruction per 2 cycles.

Test Plan:
1. Reset with RESET_PC=0x100, fetch_en=1, gnt=1, rvalid one cycle after gnt, instr_ready=1 -> imem_addr sequence 0x100, 0x104, 0x108; instr_addr 0x100, 0x104 in order with matching rdata.
2. instr_ready=0 with BUF_DEPTH=2 -> exactly 2 entries buffered, imem_req stays 0, no overflow. Then ready=1 -> entries drain in order and fetch resumes at 0x108.
3. redirect_pc=0x200 pulsed while in WAIT for 0x104 -> the 0x104 response is discarded, buffer emptied, next imem_addr=0x200, next instr_addr=0x200.
4. Redirect in the same cycle as a push and a pop -> count=0, no entry from the old stream ever appears on instr_addr.
5. redirect_pc=0x203 -> misalign_err pulses one cycle; fetch restarts at 0x200.
6. pc=0xFFFF_FFFC, gnt held low 3 cycles then high -> imem_addr stable at 0xFFFF_FFFC while waiting; next request is at 0x0000_0000. Asserting rst_n=0 mid-WAIT immediately clears imem_req and instr_valid.
